// File: rtl/adder4_arb_seq.sv
// adder4_arb_seq: two-port round-robin front end that performs a W-bit add
// nibble-serially through one shared external 4-bit adder.
module adder4_arb_seq #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         ci0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         ci1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] res,
  output logic         res_co,
  output logic         busy,
  output logic [3:0]   ad_a,
  output logic [3:0]   ad_b,
  output logic         ad_ci,
  input  logic [3:0]   ad_sum,
  input  logic         ad_co
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic          prio;
  logic          carry;
  logic [IW-1:0] idx;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_nxt;
  logic [IW+1:0] base;
  logic          last;

  assign base = {idx, 2'b00};
  assign last = (idx == IW'(NIBBLES - 1));

  always_comb begin
    ad_a  = 4'h0;
    ad_b  = 4'h0;
    ad_ci = 1'b0;
    if (state == RUN) begin
      ad_a  = opa[base +: 4];
      ad_b  = opb[base +: 4];
      ad_ci = carry;
    end
  end

  // Accumulator with the current nibble merged in, so the final
  // nibble reaches res on the same edge that enters DONE.
  always_comb begin
    acc_nxt = acc;
    acc_nxt[base +: 4] = ad_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      prio   <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      busy   <= 1'b0;
      res    <= '0;
      res_co <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 && (!req1 || !prio)) begin
            opa   <= a0;
            opb   <= b0;
            carry <= ci0;
            idx   <= '0;
            gnt0  <= 1'b1;
            busy  <= 1'b1;
            state <= RUN;
          end else if (req1) begin
            opa   <= a1;
            opb   <= b1;
            carry <= ci1;
            idx   <= '0;
            gnt1  <= 1'b1;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= ad_co;
          idx   <= idx + 1'b1;
          if (last) begin
            res    <= acc_nxt;
            res_co <= ad_co;
            done0  <= gnt0;
            done1  <= gnt1;
            state  <= DONE;
          end
        end
        DONE: begin
          // Hand priority to whichever side was not just served.
          prio  <= gnt0;
          done0 <= 1'b0;
          done1 <= 1'b0;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/adder4_arb_seq.md
Name: adder4_arb_seq

Overview:
- Nibble-serial sequencer and two-port round-robin arbiter for one shared combinational adder4 (cout, sum[3:0] = a[3:0] + b[3:0] + cin).
- Performs a W = 4*NIBBLES bit add with carry-in for either of two requesters.
- Drives one nibble per cycle through the shared adder and chains the carry in a register.
- Sits between client logic and the single adder4 instance, so multi-nibble arithmetic reuses one 4-bit datapath.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; W = 4*NIBBLES (16 by default); legal range 1..16

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req0  input  1  requester 0 add request; held high until done0
a0  input  W  requester 0 operand A; stable while req0 high
b0  input  W  requester 0 operand B
ci0  input  1  requester 0 carry-in
req1  input  1  requester 1 add request
a1  input  W  requester 1 operand A
b1  input  W  requester 1 operand B
ci1  input  1  requester 1 carry-in
gnt0  output  1  requester 0 owns the adder (RUN/DONE)
gnt1  output  1  requester 1 owns the adder
done0  output  1  one-cycle pulse: requester 0 result valid
done1  output  1  one-cycle pulse: requester 1 result valid
res  output  W  sum of last completed operation; held until next completion
res_co  output  1  carry-out of last completed operation
busy  output  1  high in RUN and DONE
ad_a  output  4  to adder4 a
ad_b  output  4  to adder4 b
ad_ci  output  1  to adder4 cin
ad_sum  input  4  from adder4 sum (combinational, same cycle)
ad_co  input  1  from adder4 cout

Behaviour:
- Reset (async, active-high): state=IDLE. gnt0, gnt1, done0, done1, busy, res, res_co, idx, carry all 0. Priority pointer = requester 0.
- State IDLE, evaluated at each rising edge:
  - No req: stay in IDLE.
  - Any req: grant one requester.
    - Both requesting: grant the requester with priority.
    - Only one requesting: grant that requester regardless of priority.
  - On grant: latch its A/B (W bits) into opA/opB, latch its ci into carry, idx=0, go to RUN.
- State RUN:
  - ad_a = opA[4*idx+3:4*idx], ad_b = opB[4*idx+3:4*idx], ad_ci = carry.
  - At each edge: acc nibble idx <= ad_sum; carry <= ad_co; idx++.
  - At the edge where idx==NIBBLES-1: go to DONE.
  - RUN lasts exactly NIBBLES cycles.
- State DONE (one cycle):
  - res = acc, res_co = carry.
  - done of the granted requester = 1; gnt of that requester stays high.
  - Priority pointer moves to the other requester.
  - Next state is IDLE, unconditionally.
- Outside RUN: ad_a, ad_b, ad_ci are driven 0.
- Latency: req sampled at edge t means done is high in cycle t+NIBBLES+1, i.e. a 5-cycle request-to-done for NIBBLES=4. Throughput is one operation per NIBBLES+2 cycles.
- Request protocol:
  - Requester must hold its operands stable while req is high.
  - Requester must drop req in the cycle after done; if req is still high in IDLE, a new operation is launched (legal back-to-back use).
  - req deasserted during RUN is ignored: the operation completes and done still pulses.
  - A req from the non-granted side waits; it is served in the next IDLE.
- Wrap-around: a carry out of the top nibble goes to res_co only; res wraps modulo 2^W.
- res and res_co are updated only in DONE; they hold their value otherwise, including in IDLE.
- res and res_co are shared: a requester must capture them in the cycle its done pulses.
- gnt0 and gnt1 are never both high. done0 and done1 are never both high.
- Reset mid-operation: all state clears immediately and asynchronously. No done is issued for the aborted operation. The requester must re-request after rst falls.
- NIBBLES=1: RUN lasts one cycle; behaviour otherwise identical.

Test Plan:
- NIBBLES=4, req0 with a0=16'h1234, b0=16'h0FFF, ci0=1 -> done0 at req edge+5; res=16'h2234, res_co=0; gnt1 stays 0.
- req1 with a1=16'hFFFF, b1=16'h0001, ci1=0 -> res=16'h0000, res_co=1. During RUN, ad_ci sequence is 0,1,1,1 and ad_a is F,F,F,F.
- After reset, req0 and req1 raised in the same cycle and held until their own done -> requester 0 served first (done0); requester 1 served next (done1 6 cycles after done0). A second simultaneous request after serving 1 -> requester 0 served first again.
- rst pulsed during the 2nd RUN cycle -> all outputs 0 immediately; no done pulse; ad_a=ad_b=0. A new req0 afterwards completes normally.
- NIBBLES=1 sweep: a,b over 0..15 with ci toggling -> every {res_co,res} equals a+b+ci; done0 two cycles after each request edge.
- Idle check: no requests for 20 cycles -> busy=0, gnt0=gnt1=0, ad_a=ad_b=ad_ci=0, res holds its last value.
